// File: rtl/distribuidor.sv
// 1-to-4 stream distributor: one upstream valid/ready source steered into four 1-entry output slots.
// Define ROUND_ROBIN_EN to deal words 0,1,2,3,0,... from an internal pointer instead of in_sel.
module distribuidor_slot #(
  parameter int NBITS = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             vld_nxt,
  input  logic [NBITS-1:0] din,
  output logic [NBITS-1:0] data,
  output logic             vld
);
  // Data only moves on load, so a drained slot keeps its last word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data <= '0;
      vld  <= 1'b0;
    end else begin
      if (load) data <= din;
      vld <= vld_nxt;
    end
  end
endmodule

module distribuidor #(
  parameter int NBITS = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [NBITS-1:0] in_data,
  input  logic             in_valid,
  input  logic [1:0]       in_sel,
  output logic             in_ready,
  output logic [NBITS-1:0] out_data0,
  output logic [NBITS-1:0] out_data1,
  output logic [NBITS-1:0] out_data2,
  output logic [NBITS-1:0] out_data3,
  output logic [3:0]       out_valid,
  input  logic [3:0]       out_ready,
  output logic [2:0]       ocupados
);
  localparam int NUM_LANES = 4;

  logic [1:0]                        d;
  logic                              accept;
  logic [NUM_LANES-1:0]              load;
  logic [NUM_LANES-1:0]              vld;
  logic [NUM_LANES-1:0]              vld_nxt;
  logic [NUM_LANES-1:0][NBITS-1:0]   data;
  logic [2:0]                        cnt_nxt;

`ifdef ROUND_ROBIN_EN
  logic [1:0] ptr;
  wire        unused_sel = ^in_sel;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      ptr <= 2'd0;
    else if (accept) ptr <= ptr + 2'd1;
  end

  assign d = ptr;
`else
  assign d = in_sel;
`endif

  assign in_ready = !vld[d] || out_ready[d];
  assign accept   = in_valid && in_ready;

  genvar k;
  generate
    for (k = 0; k < NUM_LANES; k++) begin : g_lane
      assign load[k]    = accept && (d == k);
      // Drain and refill in the same cycle keeps the slot valid.
      assign vld_nxt[k] = load[k] || (vld[k] && !out_ready[k]);

      distribuidor_slot #(.NBITS(NBITS)) u_slot (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (load[k]),
        .vld_nxt (vld_nxt[k]),
        .din     (in_data),
        .data    (data[k]),
        .vld     (vld[k])
      );
    end
  endgenerate

  always_comb begin
    cnt_nxt = 3'd0;
    for (int i = 0; i < NUM_LANES; i++) cnt_nxt = cnt_nxt + {2'b00, vld_nxt[i]};
  end

  // Occupancy registered from the same next-state as the slots, so it tracks out_valid exactly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ocupados <= 3'd0;
    else        ocupados <= cnt_nxt;
  end

  assign out_valid = vld;
  assign out_data0 = data[0];
  assign out_data1 = data[1];
  assign out_data2 = data[2];
  assign out_data3 = data[3];
endmodule

// File: tb/tb_distribuidor.sv
// Directed bench for distribuidor; default build exercises in_sel steering, ROUND_ROBIN_EN the pointer.
module tb_distribuidor;
  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] in_data;
  logic       in_valid;
  logic [1:0] in_sel;
  logic       in_ready;
  logic [3:0] out_data0, out_data1, out_data2, out_data3;
  logic [3:0] out_valid;
  logic [3:0] out_ready;
  logic [2:0] ocupados;

  int nvec = 0;
  int nerr = 0;

  distribuidor #(.NBITS(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .in_sel(in_sel), .in_ready(in_ready), .out_data0(out_data0),
    .out_data1(out_data1), .out_data2(out_data2), .out_data3(out_data3),
    .out_valid(out_valid), .out_ready(out_ready), .ocupados(ocupados)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] chan(input int c);
    case (c)
      0: return out_data0;
      1: return out_data1;
      2: return out_data2;
      default: return out_data3;
    endcase
  endfunction

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic send(input logic [1:0] sel, input logic [3:0] dat);
    in_valid = 1'b1; in_sel = sel; in_data = dat;
    step();
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    nvec++;
    if ({out_valid, ocupados, out_data0, out_data1, out_data2, out_data3} !== 23'd0) begin
      nerr++; $display("FAIL reset_init: got valid=%b occ=%0d, want all zero", out_valid, ocupados);
    end
    @(negedge clk); rst_n = 1'b1;
  endtask

`ifndef ROUND_ROBIN_EN
  task automatic test_basic();
    out_ready = 4'b0000;
    send(2'd2, 4'hA);
    nvec++;
    if (out_valid !== 4'b0100 || out_data2 !== 4'hA || ocupados !== 3'd1) begin
      nerr++; $display("FAIL basic_steer: got valid=%b d2=%h occ=%0d, want 0100 A 1", out_valid, out_data2, ocupados);
    end
    in_sel = 2'd0; #1; nvec++;
    if (in_ready !== 1'b1) begin nerr++; $display("FAIL basic_ready0: got %b want 1", in_ready); end
    in_sel = 2'd2; #1; nvec++;
    if (in_ready !== 1'b0) begin nerr++; $display("FAIL basic_ready2: got %b want 0", in_ready); end
  endtask

  task automatic test_backpressure();
    in_valid = 1'b1; in_sel = 2'd2; in_data = 4'h5; out_ready = 4'b0000;
    for (int i = 0; i < 10; i++) begin
      step(); nvec++;
      if (in_ready !== 1'b0 || out_data2 !== 4'hA || out_valid !== 4'b0100) begin
        nerr++; $display("FAIL stall_%0d: got rdy=%b d2=%h valid=%b, want 0 A 0100", i, in_ready, out_data2, out_valid);
      end
    end
    out_ready = 4'b0100; #1; nvec++;
    if (in_ready !== 1'b1) begin nerr++; $display("FAIL stall_release: got rdy=%b want 1", in_ready); end
    step();
    in_valid = 1'b0; out_ready = 4'b0000; nvec++;
    if (out_data2 !== 4'h5 || out_valid !== 4'b0100 || ocupados !== 3'd1) begin
      nerr++; $display("FAIL drain_accept: got d2=%h valid=%b occ=%0d, want 5 0100 1", out_data2, out_valid, ocupados);
    end
  endtask

  task automatic test_parallel();
    out_ready = 4'b1111; step(); out_ready = 4'b0000;
    for (int c = 0; c < 4; c++) send(c[1:0], 4'(c + 1));
    nvec++;
    if (out_valid !== 4'b1111 || ocupados !== 3'd4 ||
        {out_data3, out_data2, out_data1, out_data0} !== 16'h4321) begin
      nerr++; $display("FAIL fill_all: got valid=%b occ=%0d data=%h%h%h%h, want 1111 4 4321",
                       out_valid, ocupados, out_data3, out_data2, out_data1, out_data0);
    end
    out_ready = 4'b1111; step(); out_ready = 4'b0000; nvec++;
    if (out_valid !== 4'b0000 || ocupados !== 3'd0 ||
        {out_data3, out_data2, out_data1, out_data0} !== 16'h4321) begin
      nerr++; $display("FAIL drain_all: got valid=%b occ=%0d data=%h%h%h%h, want 0000 0 4321",
                       out_valid, ocupados, out_data3, out_data2, out_data1, out_data0);
    end
  endtask

  task automatic test_independent();
    send(2'd0, 4'h9);
    out_ready = 4'b0001;
    send(2'd3, 4'hE);
    out_ready = 4'b0000; nvec++;
    if (out_valid !== 4'b1000 || out_data3 !== 4'hE || ocupados !== 3'd1) begin
      nerr++; $display("FAIL independent: got valid=%b d3=%h occ=%0d, want 1000 E 1", out_valid, out_data3, ocupados);
    end
    out_ready = 4'b1000; step(); out_ready = 4'b0000;
  endtask

  task automatic test_reset_mid();
    send(2'd1, 4'h6);
    send(2'd3, 4'h7);
    nvec++;
    if (out_valid !== 4'b1010 || ocupados !== 3'd2) begin
      nerr++; $display("FAIL pre_reset: got valid=%b occ=%0d, want 1010 2", out_valid, ocupados);
    end
    #2 rst_n = 1'b0; #1; nvec++;
    if ({out_valid, ocupados, out_data0, out_data1, out_data2, out_data3} !== 23'd0) begin
      nerr++; $display("FAIL reset_async: got valid=%b occ=%0d d1=%h d3=%h, want all zero",
                       out_valid, ocupados, out_data1, out_data3);
    end
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_back_to_back();
    out_ready = 4'b1111; in_valid = 1'b1; in_sel = 2'd1;
    for (int i = 0; i < 16; i++) begin
      in_data = 4'(i); #1; nvec++;
      if (in_ready !== 1'b1) begin nerr++; $display("FAIL stream_rdy_%0d: got %b want 1", i, in_ready); end
      step(); nvec++;
      if (out_data1 !== 4'(i) || out_valid !== 4'b0010 || ocupados !== 3'd1) begin
        nerr++; $display("FAIL stream_%0d: got d1=%h valid=%b occ=%0d, want %h 0010 1", i, out_data1, out_valid, ocupados, 4'(i));
      end
    end
    in_valid = 1'b0; step(); nvec++;
    if (out_valid !== 4'b0000 || ocupados !== 3'd0) begin
      nerr++; $display("FAIL stream_end: got valid=%b occ=%0d, want 0000 0", out_valid, ocupados);
    end
  endtask
`else
  task automatic test_round_robin();
    logic [3:0] words [5];
    int         exp_ch [5];
    words = '{4'h7, 4'h8, 4'h9, 4'hB, 4'hC};
    exp_ch = '{0, 1, 2, 3, 0};
    out_ready = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      if (i == 3) begin
        in_valid = 1'b0; in_sel = 2'd2; step();
      end
      send(2'($urandom_range(0, 3)), words[i]);
      nvec++;
      if (out_valid !== (4'b0001 << exp_ch[i]) || chan(exp_ch[i]) !== words[i]) begin
        nerr++; $display("FAIL rr_%0d: got valid=%b data=%h, want ch %0d data %h",
                         i, out_valid, chan(exp_ch[i]), exp_ch[i], words[i]);
      end
    end
    step();
  endtask
`endif

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_sel = 2'd0; in_data = 4'h0; out_ready = 4'b0000;
    #3;
    test_reset();
`ifdef ROUND_ROBIN_EN
    test_round_robin();
`else
    test_basic();
    test_backpressure();
    test_parallel();
    test_independent();
    test_reset_mid();
    test_back_to_back();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule

// File: doc/distribuidor.md
Name: distribuidor

Overview:
- 1-to-4 stream distributor; the scatter counterpart to the 4:1 `roteamento` selector.
- Accepts one NBITS word per handshake from a single upstream source.
- Steers each word to one of four output channels. Each channel is held in a 1-entry register slot until its consumer takes it.
- Sits between a single producer and four independent consumers in the lab datapath.

Parameters:
- NBITS, 4, width of each data word.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_data  input  NBITS  word offered by the producer.
- in_valid  input  1  producer has a word on in_data.
- in_sel  input  2  destination channel (0..3) for in_data; ignored when ROUND_ROBIN_EN is defined.
- in_ready  output  1  distributor accepts in_data this cycle.
- out_data0, out_data1, out_data2, out_data3  output  NBITS each  slot contents of channels 0..3.
- out_valid  output  4  bit k set: slot k holds a word.
- out_ready  input  4  bit k set: consumer k takes slot k this cycle.
- ocupados  output  3  number of occupied slots (0..4).

Behaviour:
- One clock, clk. Reset is asynchronous and active-low on rst_n.
- Reset (rst_n=0, asynchronous, any cycle including mid-transfer):
  - out_valid=4'b0000; out_data0..3 = 0; ocupados=0.
  - Round-robin pointer = 0.
  - Any pending word is discarded.
  - Outputs stay in reset values while rst_n=0. Normal operation resumes on the first rising edge after deassertion.
- Destination d = in_sel (or pointer, see Optional Feature).
- in_ready is combinational: in_ready = !out_valid[d] || out_ready[d]. It depends on out_ready[d] and d only, never on in_valid.
- Accept: in_valid && in_ready at a rising edge. Next cycle out_data_d=in_data and out_valid[d]=1. Latency is 1 cycle from accept to visible output.
- Drain: out_valid[k] && out_ready[k] at a rising edge clears out_valid[k]. out_data_k keeps its old value; it is don't-care while invalid but must not change randomly.
- Simultaneous drain and accept on the same slot k: slot holds the new word, out_valid[k] stays 1. This gives full throughput of 1 word/cycle per channel.
- Channels are independent. Draining k != d the same cycle as an accept into d is legal, and any subset of slots may drain in one cycle.
- Full slot with out_ready[d]=0: in_ready=0 and the producer stalls. in_data/in_sel must be held by the producer (standard valid/ready rule). Other channels continue draining.
- out_valid[k]=1 and out_data_k stay stable until drained (no overwrite without a drain).
- ocupados = popcount(out_valid), registered alongside out_valid (no extra latency relative to out_valid).
- Width rules: no arithmetic on data. The pointer is 2 bits and wraps 3 -> 0. ocupados saturates naturally at 4.
- out_ready bits for empty slots are ignored.

Optional Feature:
- ROUND_ROBIN_EN
- Defined:
  - in_sel is ignored; d = internal 2-bit pointer.
  - Pointer increments (3 wraps to 0) on every accepted word only. It holds while stalled or idle.
  - Effect: words are dealt 0,1,2,3,0,... to consumers.
- Undefined:
  - d = in_sel and no pointer register exists.
  - Reset behaviour is otherwise identical.

Test Plan:
- Reset: rst_n=0 pulsed mid-stream with slots 1 and 3 full -> out_valid=0000, all out_data=0, ocupados=0 immediately, without waiting for a clk edge.
- Basic steer: out_ready=0000; send 4'hA sel=2 -> next cycle out_valid=0100, out_data2=A, ocupados=1, in_ready=1 for sel=0.
- Backpressure: slot 2 full, out_ready=0000, in_valid=1 sel=2 data=5 -> in_ready=0 and slot 2 keeps A for 10 cycles. Raise out_ready[2] -> same edge accepts 5; out_data2=5, out_valid[2] stays 1.
- Parallel: fill all slots with 1,2,3,4 (ocupados=4); out_ready=1111 for one cycle with no input -> out_valid=0000, ocupados=0.
- Full throughput: out_ready=1111, in_valid=1 sel=1 streaming 0..F -> in_ready constantly 1; out_data1 follows input one cycle late.
- ROUND_ROBIN_EN defined: send 7,8,9,B,C with out_ready=1111 and arbitrary in_sel -> words land in channels 0,1,2,3,0. A stall cycle (in_valid=0) does not advance the pointer.
